// File: rtl/isqrt_iter_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_iter_fsm_if
// Brief    : Request/response bundle between an isqrt initiator and the
//            iterative square-root responder. The request side is a strobe
//            plus operand with no backpressure. The response side is a
//            one-cycle result pulse plus status flags.
// Revision : 1.0 - initial release
// ============================================================================
interface isqrt_iter_fsm_if;
  logic        x_vld;     // request strobe
  logic [31:0] x;         // unsigned radicand
  logic        y_vld;     // one-cycle result pulse
  logic [15:0] y;         // floor(sqrt(x)), held between pulses
  logic        busy;      // core calculating or requests queued
  logic        overflow;  // sticky: a request was dropped

  // Initiator side: drives requests, observes results and status.
  modport master (
    output x_vld,
    output x,
    input  y_vld,
    input  y,
    input  busy,
    input  overflow
  );

  // Responder side: the square-root engine.
  modport slave (
    input  x_vld,
    input  x,
    output y_vld,
    output y,
    output busy,
    output overflow
  );
endinterface
`default_nettype wire

// File: rtl/isqrt_iter_fsm.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_iter_fsm
// Brief    : Iterative integer square root, y = floor(sqrt(x)), with x as a
//            32-bit value and y as a 16-bit value. The restoring
//            digit-by-digit algorithm consumes two radicand bits per clock,
//            so each result takes 16 iterations plus one DONE cycle. A small
//            input FIFO queues requests that arrive while the core is busy.
//            Results return in acceptance order.
// Revision : 1.0 - initial release
// ============================================================================
module isqrt_iter_fsm #(
  parameter int FIFO_DEPTH = 4   // queued requests while the core is busy (>= 1)
) (
  input  wire logic       clk,
  input  wire logic       rst,   // asynchronous, active-low
  isqrt_iter_fsm_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // A depth-1 FIFO still needs a 1-bit pointer to keep the widths legal.
  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(FIFO_DEPTH - 1);
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // Core state machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // nothing in flight
    ST_CALC = 2'd1,   // 16 iterations, r_iter counts 15..0
    ST_DONE = 2'd2    // result pulse, exactly one cycle
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // --------------------------------------------------------------------------
  // Request FIFO
  // --------------------------------------------------------------------------
  logic [31:0]        r_fifo [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_overflow;

  // --------------------------------------------------------------------------
  // Core datapath registers
  // --------------------------------------------------------------------------
  logic [17:0] r_rem;     // partial remainder
  logic [15:0] r_root;    // partial root
  logic [31:0] r_shift;   // radicand, consumed two MSBs per iteration
  logic [3:0]  r_iter;    // iterations left after the current one
  logic [15:0] r_y;       // last completed result

  // --------------------------------------------------------------------------
  // Combinational control and datapath
  // --------------------------------------------------------------------------
  logic        w_load_op;
  logic        w_full;
  logic        w_pop;
  logic        w_bypass;
  logic        w_push_req;
  logic        w_push;
  logic        w_drop;
  logic        w_load;
  logic [31:0] w_load_x;

  logic [19:0] w_rem_sh;
  logic [19:0] w_trial;
  logic [19:0] w_diff;
  logic        w_ge;
  logic [17:0] w_rem_nxt;
  logic [15:0] w_root_nxt;
  logic        w_last_iter;

  // Pointer advance with wrap at the configured depth, which may not be a
  // power of two.
  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_last_ptr) ? '0 : p + c_ptr_w'(1);
  endfunction

  // Arbitrate one request per edge between the FIFO head, the bypass path
  // and the FIFO tail.
  always_comb begin
    w_load_op  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    w_full     = (r_count == c_full_cnt);
    // Queued work always takes priority so that results stay in order.
    w_pop      = w_load_op && (r_count != '0);
    // An idle core with an empty queue takes the request directly.
    w_bypass   = w_load_op && (r_count == '0) && bus.x_vld;
    w_push_req = bus.x_vld && !w_bypass;
    // A full FIFO can still accept when its head leaves on the same edge.
    w_push     = w_push_req && (!w_full || w_pop);
    w_drop     = w_push_req && w_full && !w_pop;
    w_load     = w_pop || w_bypass;
    w_load_x   = w_pop ? r_fifo[r_rd_ptr] : bus.x;
  end

  // Compute one restoring iteration: bring in two radicand bits, then try to
  // subtract (4*root + 1).
  always_comb begin
    w_rem_sh    = {r_rem, r_shift[31:30]};
    w_trial     = {2'b00, r_root, 2'b01};
    w_ge        = (w_rem_sh >= w_trial);
    w_diff      = w_rem_sh - w_trial;
    // The remainder never exceeds 2*root, so it always fits in 18 bits.
    w_rem_nxt   = 18'(w_ge ? w_diff : w_rem_sh);
    w_root_nxt  = {r_root[14:0], w_ge};
    w_last_iter = (r_iter == 4'd0);
  end

  // Select the next core state from the load decision and the iteration count.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE,
      ST_DONE: w_state_nxt = w_load ? ST_CALC : ST_IDLE;
      ST_CALC: begin
        if (w_last_iter) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Hold the core state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Load a new radicand or run one iteration. Capture the root when the last
  // iteration completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem   <= '0;
      r_root  <= '0;
      r_shift <= '0;
      r_iter  <= '0;
      r_y     <= '0;
    end else if (w_load) begin
      r_rem   <= '0;
      r_root  <= '0;
      r_shift <= w_load_x;
      r_iter  <= 4'd15;
    end else if (r_state == ST_CALC) begin
      r_rem   <= w_rem_nxt;
      r_root  <= w_root_nxt;
      r_shift <= {r_shift[29:0], 2'b00};
      r_iter  <= r_iter - 4'd1;
      if (w_last_iter) begin
        r_y <= w_root_nxt;
      end
    end
  end

  // Track FIFO occupancy and pointers, and latch the sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Write queued radicands. The storage needs no reset because occupancy is
  // tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= bus.x;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.y_vld    = (r_state == ST_DONE);
  assign bus.y        = r_y;
  assign bus.busy     = (r_state != ST_IDLE) || (r_count != '0);
  assign bus.overflow = r_overflow;

endmodule
`default_nettype wire
